// File: rtl/hist_eq_mapper_pkg.sv
// Shared sizes and FSM state type for the histogram-equalisation mapper.
package hist_eq_pkg;

  localparam int BINS    = 256;
  localparam int PIX_W   = 8;
  localparam int CDF_W   = 24;
  localparam int NUM_W   = 32;
  localparam int DIV_CYC = 8;

  // One LUT entry: RAM read, DIV_CYC divide steps, LUT write.
  localparam int PHASES  = DIV_CYC + 2;

  typedef enum logic [1:0] {
    LOAD,
    CALC,
    RUN,
    DRAIN
  } state_e;

endpackage

// File: rtl/eq_div8.sv
// Sequential restoring divider producing an 8-bit quotient. The caller
// guarantees numerator < 256 * denominator, so the top 24 numerator bits
// start out smaller than the denominator and every partial remainder fits
// in CDF_W bits. The first quotient bit is resolved on the start edge, so
// the full quotient is ready (done high) DIV_CYC cycles after start.
module eq_div8
  import hist_eq_pkg::*;
(
  input  logic             clk,
  input  logic             reset,
  input  logic             start,
  input  logic [NUM_W-1:0] numerator,
  input  logic [CDF_W-1:0] denominator,
  output logic [PIX_W-1:0] quotient,
  output logic             done
);

  logic [CDF_W-1:0] rem_q, rem_d;
  logic [PIX_W-1:0] bits_q, bits_d;
  logic [PIX_W-1:0] quo_q, quo_d;
  logic [3:0]       cnt_q, cnt_d;
  logic             done_q, done_d;

  logic [CDF_W-1:0] stepRemIn;
  logic             stepBit;
  logic [CDF_W:0]   trial;
  logic             stepGe;
  logic [CDF_W-1:0] stepRem;

  // One restoring step: shift in the next numerator bit, subtract if it fits.
  always_comb begin
    stepRemIn = start ? numerator[NUM_W-1:PIX_W] : rem_q;
    stepBit   = start ? numerator[PIX_W-1] : bits_q[PIX_W-1];
    trial     = {stepRemIn, stepBit};
    stepGe    = trial >= {1'b0, denominator};
    stepRem   = stepGe ? (trial[CDF_W-1:0] - denominator) : trial[CDF_W-1:0];
  end

  // Sequencing: load on start, iterate while the step counter is nonzero.
  always_comb begin
    rem_d  = rem_q;
    bits_d = bits_q;
    quo_d  = quo_q;
    cnt_d  = cnt_q;
    done_d = 1'b0;
    if (start) begin
      rem_d  = stepRem;
      bits_d = {numerator[PIX_W-2:0], 1'b0};
      quo_d  = {{(PIX_W-1){1'b0}}, stepGe};
      cnt_d  = 4'(DIV_CYC - 1);
    end else if (cnt_q != 4'd0) begin
      rem_d  = stepRem;
      bits_d = {bits_q[PIX_W-2:0], 1'b0};
      quo_d  = {quo_q[PIX_W-2:0], stepGe};
      cnt_d  = cnt_q - 4'd1;
      done_d = (cnt_q == 4'd1);
    end
  end

  // Divider state registers.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      rem_q  <= '0;
      bits_q <= '0;
      quo_q  <= '0;
      cnt_q  <= '0;
      done_q <= 1'b0;
    end else begin
      rem_q  <= rem_d;
      bits_q <= bits_d;
      quo_q  <= quo_d;
      cnt_q  <= cnt_d;
      done_q <= done_d;
    end
  end

  assign quotient = quo_q;
  assign done     = done_q;

endmodule

// File: rtl/hist_eq_mapper.sv
// Histogram-equalisation mapper: loads a 256-bin CDF, turns it into an
// 8-bit remap LUT with a shared serial divider, then remaps a pixel stream
// through that LUT until a new CDF arrives.
module hist_eq_mapper
  import hist_eq_pkg::*;
(
  input  logic             clk,
  input  logic             reset,
  input  logic             cdf_valid,
  output logic             cdf_ready,
  input  logic [CDF_W-1:0] cdf_data,
  input  logic             cdf_last,
  input  logic             pix_in_valid,
  output logic             pix_in_ready,
  input  logic [PIX_W-1:0] pix_in,
  output logic             pix_out_valid,
  input  logic             pix_out_ready,
  output logic [PIX_W-1:0] pix_out,
  output logic             lut_valid,
  output logic             cdf_err
);

  state_e           state_q, state_d;
  logic [7:0]       idx_q, idx_d;
  logic [CDF_W-1:0] cdfMin_q, cdfMin_d;
  logic [CDF_W-1:0] total_q, total_d;
  logic [CDF_W-1:0] prev_q, prev_d;
  logic [7:0]       calcIdx_q, calcIdx_d;
  logic [3:0]       phase_q, phase_d;
  logic             cdfErr_q, cdfErr_d;
  logic             outValid_q, outValid_d;
  logic [PIX_W-1:0] pixOut_q, pixOut_d;

  logic [CDF_W-1:0] cdfMem [BINS];
  logic [CDF_W-1:0] cdfRd_q;
  logic [PIX_W-1:0] lutMem [BINS];

  logic             cdfAccept, atLast, loadErr, cdfWe;
  logic             divStart, divDone;
  logic [NUM_W-1:0] divNum;
  logic [CDF_W-1:0] divDen;
  logic [PIX_W-1:0] divQuo;
  logic             belowMin, flatCdf, lutWe;
  logic [PIX_W-1:0] lutWrData;
  logic             pixInReady, pixAccept;

  // Load-side checks: last flag must coincide with bin 255 and the CDF must not decrease.
  always_comb begin
    cdfAccept = (state_q == LOAD) && cdf_valid;
    atLast    = (idx_q == 8'd255);
    loadErr   = cdfAccept &&
                ((cdf_last != atLast) || ((idx_q != 8'd0) && (cdf_data < prev_q)));
    cdfWe     = cdfAccept && !loadErr;
  end

  // LUT entry value; a single-level CDF has no spread to stretch, so it maps identically.
  always_comb begin
    divStart  = (state_q == CALC) && (phase_q == 4'd1);
    divNum    = NUM_W'(cdfRd_q - cdfMin_q) * 32'd255;
    divDen    = total_q - cdfMin_q;
    belowMin  = cdfRd_q < cdfMin_q;
    flatCdf   = total_q == cdfMin_q;
    lutWe     = (state_q == CALC) && (phase_q == 4'(PHASES - 1)) && divDone;
    lutWrData = flatCdf  ? calcIdx_q :
                belowMin ? '0 : divQuo;
  end

  eq_div8 u_div (
    .clk         (clk),
    .reset       (reset),
    .start       (divStart),
    .numerator   (divNum),
    .denominator (divDen),
    .quotient    (divQuo),
    .done        (divDone)
  );

  // CDF RAM: written while loading, read one entry at a time while calculating.
  always_ff @(posedge clk) begin
    if (cdfWe) cdfMem[idx_q] <= cdf_data;
    cdfRd_q <= cdfMem[calcIdx_q];
  end

  // LUT RAM write port, filled at the end of each calculation entry.
  always_ff @(posedge clk) begin
    if (lutWe) lutMem[calcIdx_q] <= lutWrData;
  end

  // FSM next state.
  always_comb begin
    state_d = state_q;
    case (state_q)
      LOAD:    if (cdfWe && atLast) state_d = CALC;
      CALC:    if (lutWe && (calcIdx_q == 8'd255)) state_d = RUN;
      RUN:     if (cdf_valid) state_d = DRAIN;
      DRAIN:   if (!outValid_q || pix_out_ready) state_d = LOAD;
      default: state_d = LOAD;
    endcase
  end

  // Load bookkeeping and calculation sequencing.
  always_comb begin
    idx_d     = idx_q;
    cdfMin_d  = cdfMin_q;
    total_d   = total_q;
    prev_d    = prev_q;
    calcIdx_d = calcIdx_q;
    phase_d   = phase_q;
    cdfErr_d  = cdfErr_q;
    if (loadErr) begin
      cdfErr_d = 1'b1;
      idx_d    = 8'd0;
      cdfMin_d = '0;
      prev_d   = '0;
    end else if (cdfWe) begin
      prev_d = cdf_data;
      if ((cdfMin_q == '0) && (cdf_data != '0)) cdfMin_d = cdf_data;
      if (atLast) begin
        total_d   = cdf_data;
        idx_d     = 8'd0;
        calcIdx_d = 8'd0;
        phase_d   = 4'd0;
      end else begin
        idx_d = idx_q + 8'd1;
      end
    end
    if (state_q == CALC) begin
      if (phase_q == 4'(PHASES - 1)) begin
        phase_d   = 4'd0;
        calcIdx_d = calcIdx_q + 8'd1;
      end else begin
        phase_d = phase_q + 4'd1;
      end
    end
    if ((state_q == DRAIN) && (state_d == LOAD)) begin
      idx_d    = 8'd0;
      cdfMin_d = '0;
      prev_d   = '0;
    end
  end

  // Pixel path: one-deep output register that reloads in the same cycle it drains.
  always_comb begin
    pixInReady = (state_q == RUN) && (!outValid_q || pix_out_ready);
    pixAccept  = pix_in_valid && pixInReady;
    outValid_d = pixAccept ? 1'b1 : (pix_out_ready ? 1'b0 : outValid_q);
    pixOut_d   = pixAccept ? lutMem[pix_in] : pixOut_q;
  end

  // All control and pixel-path registers.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q    <= LOAD;
      idx_q      <= 8'd0;
      cdfMin_q   <= '0;
      total_q    <= '0;
      prev_q     <= '0;
      calcIdx_q  <= 8'd0;
      phase_q    <= 4'd0;
      cdfErr_q   <= 1'b0;
      outValid_q <= 1'b0;
      pixOut_q   <= '0;
    end else begin
      state_q    <= state_d;
      idx_q      <= idx_d;
      cdfMin_q   <= cdfMin_d;
      total_q    <= total_d;
      prev_q     <= prev_d;
      calcIdx_q  <= calcIdx_d;
      phase_q    <= phase_d;
      cdfErr_q   <= cdfErr_d;
      outValid_q <= outValid_d;
      pixOut_q   <= pixOut_d;
    end
  end

  assign cdf_ready     = (state_q == LOAD);
  assign lut_valid     = (state_q == RUN) || (state_q == DRAIN);
  assign pix_in_ready  = pixInReady;
  assign pix_out_valid = outValid_q;
  assign pix_out       = pixOut_q;
  assign cdf_err       = cdfErr_q;

endmodule

// File: tb/tb_hist_eq_mapper.sv
// Directed bench for hist_eq_mapper: CDF loads, LUT values, pixel handshake,
// drain behaviour, protocol errors and reset.
module tb_hist_eq_mapper;

  logic        clk;
  logic        reset;
  logic        cdf_valid;
  logic        cdf_ready;
  logic [23:0] cdf_data;
  logic        cdf_last;
  logic        pix_in_valid;
  logic        pix_in_ready;
  logic [7:0]  pix_in;
  logic        pix_out_valid;
  logic        pix_out_ready;
  logic [7:0]  pix_out;
  logic        lut_valid;
  logic        cdf_err;

  int checks = 0;
  int errors = 0;

  hist_eq_mapper dut (
    .clk           (clk),
    .reset         (reset),
    .cdf_valid     (cdf_valid),
    .cdf_ready     (cdf_ready),
    .cdf_data      (cdf_data),
    .cdf_last      (cdf_last),
    .pix_in_valid  (pix_in_valid),
    .pix_in_ready  (pix_in_ready),
    .pix_in        (pix_in),
    .pix_out_valid (pix_out_valid),
    .pix_out_ready (pix_out_ready),
    .pix_out       (pix_out),
    .lut_valid     (lut_valid),
    .cdf_err       (cdf_err)
  );

  // 100 MHz-style free-running clock.
  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Hard stop in case something wedges beyond every bounded wait.
  initial begin
    #2000000;
    $display("[TB] FAIL watchdog observed=timeout expected=finish");
    $fatal(1, "[TB] watchdog expired");
  end

  // Reference CDF tables: 0 uniform, 1 two-level, 2 single-level.
  function automatic logic [23:0] pattern(input int mode, input int i);
    case (mode)
      0:       return 24'((i + 1) * 1200);
      1:       return (i < 10) ? 24'd0 : ((i < 200) ? 24'd1000 : 24'd2000);
      default: return (i < 100) ? 24'd0 : 24'd307200;
    endcase
  endfunction

  task automatic checkOutput(input string tag, input logic [31:0] observed,
                             input logic [31:0] expected);
    checks++;
    assert (observed === expected) else begin
      errors++;
      $display("[TB] FAIL %s observed=%0d expected=%0d", tag, observed, expected);
      $error("[TB] check %s did not hold", tag);
    end
  endtask

  task automatic sendBeat(input logic [23:0] data, input logic last);
    logic acc;
    int   n;
    cdf_valid = 1'b1;
    cdf_data  = data;
    cdf_last  = last;
    acc = 1'b0;
    n   = 0;
    while (!acc && n < 20) begin
      acc = cdf_ready;
      @(posedge clk);
      #1;
      n++;
    end
    if (!acc) checkOutput("beat_accept", 32'(acc), 32'd1);
  endtask

  task automatic applyStimulus(input int mode);
    for (int i = 0; i < 256; i++) sendBeat(pattern(mode, i), (i == 255));
    cdf_valid = 1'b0;
    cdf_last  = 1'b0;
  endtask

  task automatic waitLut();
    int n;
    n = 0;
    while (!lut_valid && n < 3000) begin
      @(posedge clk);
      #1;
      n++;
    end
    checkOutput("lut_valid_rise", 32'(lut_valid), 32'd1);
  endtask

  task automatic sendPixel(input logic [7:0] pix, input logic [7:0] expPix, input string tag);
    pix_out_ready = 1'b1;
    pix_in_valid  = 1'b1;
    pix_in        = pix;
    @(posedge clk);
    #1;
    pix_in_valid = 1'b0;
    checkOutput({tag, "_valid"}, 32'(pix_out_valid), 32'd1);
    checkOutput(tag, 32'(pix_out), 32'(expPix));
  endtask

  initial begin
    int  sent;
    int  recv;
    int  cyc;
    logic inFire;

    reset         = 1'b1;
    cdf_valid     = 1'b0;
    cdf_data      = '0;
    cdf_last      = 1'b0;
    pix_in_valid  = 1'b0;
    pix_in        = '0;
    pix_out_ready = 1'b1;

    // Reset state.
    repeat (2) @(posedge clk);
    #1;
    checkOutput("rst_lut_valid", 32'(lut_valid), 32'd0);
    checkOutput("rst_cdf_err", 32'(cdf_err), 32'd0);
    checkOutput("rst_pix_out_valid", 32'(pix_out_valid), 32'd0);
    checkOutput("rst_pix_out", 32'(pix_out), 32'd0);
    reset = 1'b0;
    @(posedge clk);
    #1;
    checkOutput("rst_cdf_ready", 32'(cdf_ready), 32'd1);

    // Uniform CDF: exact calculation length and identity mapping.
    applyStimulus(0);
    checkOutput("calc_cdf_ready", 32'(cdf_ready), 32'd0);
    repeat (2559) @(posedge clk);
    #1;
    checkOutput("calc_lut_valid_low", 32'(lut_valid), 32'd0);
    @(posedge clk);
    #1;
    checkOutput("calc_lut_valid_high", 32'(lut_valid), 32'd1);
    sendPixel(8'd0, 8'd0, "uni_pix0");
    sendPixel(8'd17, 8'd17, "uni_pix17");
    sendPixel(8'd255, 8'd255, "uni_pix255");

    // Back-to-back pixels with ready held high.
    pix_out_ready = 1'b1;
    for (int k = 0; k < 6; k++) begin
      pix_in_valid = 1'b1;
      pix_in       = 8'(3 + k);
      #1;
      checkOutput("thru_in_ready", 32'(pix_in_ready), 32'd1);
      @(posedge clk);
      #1;
      checkOutput("thru_valid", 32'(pix_out_valid), 32'd1);
      checkOutput("thru_pix", 32'(pix_out), 32'(3 + k));
    end
    pix_in_valid = 1'b0;
    @(posedge clk);
    #1;

    // Output ready toggling every cycle: order and count must be preserved.
    sent = 0;
    recv = 0;
    cyc  = 0;
    while (recv < 8 && cyc < 60) begin
      pix_out_ready = (cyc % 2 == 0);
      pix_in_valid  = (sent < 8);
      pix_in        = 8'(100 + sent);
      #1;
      inFire = pix_in_valid && pix_in_ready;
      if (pix_out_valid && pix_out_ready) begin
        checkOutput("toggle_order", 32'(pix_out), 32'(100 + recv));
        recv++;
      end
      if (inFire) sent++;
      @(posedge clk);
      #1;
      cyc++;
    end
    pix_in_valid  = 1'b0;
    pix_out_ready = 1'b1;
    checkOutput("toggle_count", 32'(recv), 32'd8);

    // New CDF arrives while a pixel is stuck behind backpressure.
    pix_out_ready = 1'b0;
    pix_in_valid  = 1'b1;
    pix_in        = 8'd42;
    @(posedge clk);
    #1;
    pix_in_valid = 1'b0;
    checkOutput("drain_pending_valid", 32'(pix_out_valid), 32'd1);
    cdf_valid = 1'b1;
    cdf_data  = pattern(1, 0);
    cdf_last  = 1'b0;
    @(posedge clk);
    #1;
    checkOutput("drain_lut_valid", 32'(lut_valid), 32'd1);
    checkOutput("drain_cdf_ready", 32'(cdf_ready), 32'd0);
    @(posedge clk);
    #1;
    checkOutput("drain_hold_valid", 32'(pix_out_valid), 32'd1);
    checkOutput("drain_hold_pix", 32'(pix_out), 32'd42);
    pix_out_ready = 1'b1;
    #1;
    checkOutput("drain_in_ready", 32'(pix_in_ready), 32'd0);
    @(posedge clk);
    #1;
    checkOutput("drain_to_load", 32'(cdf_ready), 32'd1);
    checkOutput("drain_out_empty", 32'(pix_out_valid), 32'd0);
    checkOutput("drain_lut_invalid", 32'(lut_valid), 32'd0);

    // Two-level CDF: below-minimum zeroing and top-end scaling.
    applyStimulus(1);
    waitLut();
    sendPixel(8'd5, 8'd0, "two_pix5");
    sendPixel(8'd10, 8'd0, "two_pix10");
    sendPixel(8'd150, 8'd0, "two_pix150");
    sendPixel(8'd200, 8'd255, "two_pix200");

    // Single-level CDF maps identically.
    applyStimulus(2);
    waitLut();
    sendPixel(8'd100, 8'd100, "flat_pix100");
    sendPixel(8'd7, 8'd7, "flat_pix7");
    checkOutput("no_err_yet", 32'(cdf_err), 32'd0);

    // Early last flag at bin 128, then a clean reload.
    for (int i = 0; i < 128; i++) sendBeat(pattern(0, i), 1'b0);
    sendBeat(pattern(0, 128), 1'b1);
    cdf_valid = 1'b0;
    cdf_last  = 1'b0;
    checkOutput("early_last_err", 32'(cdf_err), 32'd1);
    checkOutput("early_last_load", 32'(cdf_ready), 32'd1);
    checkOutput("early_last_lut", 32'(lut_valid), 32'd0);
    applyStimulus(1);
    waitLut();
    sendPixel(8'd200, 8'd255, "reload_pix200");
    checkOutput("err_sticky", 32'(cdf_err), 32'd1);

    // Reset in the middle of the calculation.
    applyStimulus(0);
    repeat (100) @(posedge clk);
    #1;
    reset = 1'b1;
    #1;
    checkOutput("midcalc_rst_lut", 32'(lut_valid), 32'd0);
    checkOutput("midcalc_rst_err", 32'(cdf_err), 32'd0);
    reset = 1'b0;
    @(posedge clk);
    #1;
    checkOutput("midcalc_load", 32'(cdf_ready), 32'd1);
    repeat (2600) @(posedge clk);
    #1;
    checkOutput("midcalc_stays_load", 32'(lut_valid), 32'd0);

    // Decreasing beat.
    for (int i = 0; i < 5; i++) sendBeat(pattern(0, i), 1'b0);
    sendBeat(24'd100, 1'b0);
    cdf_valid = 1'b0;
    checkOutput("decr_err", 32'(cdf_err), 32'd1);
    checkOutput("decr_load", 32'(cdf_ready), 32'd1);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/hist_eq_mapper.md
HIST_EQ_MAPPER -- requirements
Module: hist_eq_mapper

Interface
REQ-001 clk  in  1  rising-edge clock for all logic.
REQ-002 reset  in  1  asynchronous, active-high reset.
REQ-003 cdf_valid  in  1  CDF beat valid.
REQ-004 cdf_ready  out  1  CDF beat accepted when cdf_valid && cdf_ready.
REQ-005 cdf_data  in  24  cumulative count for the current bin; bins arrive in order 0..255.
REQ-006 cdf_last  in  1  marks bin 255.
REQ-007 pix_in_valid / pix_in_ready  in / out  1 / 1  input pixel handshake.
REQ-008 pix_in  in  8  grey pixel to remap.
REQ-009 pix_out_valid / pix_out_ready  out / in  1 / 1  output pixel handshake.
REQ-010 pix_out  out  8  equalized pixel.
REQ-011 lut_valid  out  1  LUT is built and the pixel path is live.
REQ-012 cdf_err  out  1  sticky error flag; cleared only by reset.

Function
REQ-013 FSM states: LOAD, CALC, RUN, DRAIN.
- Exits reset into LOAD.
- cdf_ready = 1 only in LOAD.
REQ-014 LOAD: each accepted beat writes cdf_data to CDF RAM[idx], then idx increments.
- cdf_min is latched as the first nonzero beat.
- total is latched as the beat at idx 255.
REQ-015 Load errors: cdf_last at idx != 255, cdf_last absent at idx 255, or a beat smaller than the previous beat.
- Sets cdf_err, discards the table, resets idx to 0, stays in LOAD.
REQ-016 A valid beat at idx 255 with cdf_last moves the FSM to CALC on the next cycle.
REQ-017 CALC: for i = 0..255, each entry takes exactly 10 cycles.
- 1 cycle RAM read, 8 cycles restoring division (8 quotient bits), 1 cycle LUT write.
- CALC lasts 2560 cycles.
REQ-018 LUT[i] by case:
- cdf[i] < cdf_min: LUT[i] = 0.
- total == cdf_min: LUT[i] = i.
- Otherwise: LUT[i] = floor((cdf[i] - cdf_min) * 255 / (total - cdf_min)).
- Numerator is 32 bits wide; the quotient never exceeds 255.
REQ-019 lut_valid rises the cycle after the final LUT write and the FSM enters RUN.
- lut_valid stays high in RUN and DRAIN; it is low in LOAD and CALC.
REQ-020 RUN handshake: pix_in_ready = !pix_out_valid || pix_out_ready.
- LUT read is synchronous; latency is 1 cycle from input acceptance to pix_out_valid.
- Full throughput is 1 pixel/cycle.
REQ-021 pix_out and pix_out_valid hold stable while pix_out_valid && !pix_out_ready.
REQ-022 cdf_valid asserted in RUN moves the FSM to DRAIN next cycle.
- DRAIN forces pix_in_ready = 0.
- DRAIN exits to LOAD the cycle after the output register empties.
- The pending pixel is delivered with the old LUT.
REQ-023 When accepted-in and consumed-out occur in the same cycle, the register reloads with no bubble.

Reset
REQ-024 Reset values:
- state = LOAD, idx = 0, cdf_min = 0, total = 0.
- lut_valid = 0, cdf_err = 0, pix_out_valid = 0, pix_out = 0.
- cdf_ready = 1 in the first cycle after reset release.
REQ-025 Reset mid-LOAD, mid-CALC or mid-RUN:
- Abandons the operation and drops any pending output pixel.
- RAM contents are don't-care and are not cleared.

Structure
REQ-026 Package hist_eq_pkg holds: BINS = 256, PIX_W = 8, CDF_W = 24, NUM_W = 32, DIV_CYC = 8, and the FSM state enum.
REQ-027 Sub-module eq_div8: sequential restoring divider.
- Ports: start, 32-bit numerator, 24-bit denominator, 8-bit quotient, done after 8 cycles.
REQ-028 CDF RAM (256x24) and LUT RAM (256x8) use single-clock synchronous-read inference.

Verification
REQ-029 Uniform load cdf[i] = (i+1)*1200 -> after 2560 CALC cycles lut_valid = 1; pixels 0, 17, 255 -> 0, 17, 255.
REQ-030 Two-level load to check below-min zeroing and end scaling:
- cdf = 0 for i<10, 1000 for 10..199, 2000 for 200..255.
- Pixels 5, 10, 150, 200 -> 0, 0, 0, 255.
REQ-031 Single-level load cdf = 0 for i<100, 307200 for i>=100 -> identity: pixels 100 -> 100, 7 -> 7.
REQ-032 Protocol errors:
- cdf_last at idx 128 -> cdf_err = 1, FSM stays in LOAD, next correct load succeeds.
- Decreasing beat -> cdf_err = 1.
REQ-033 RUN with pix_out_ready toggled 1/0 each cycle -> no pixel lost, duplicated or reordered; ready held high -> 1 pixel/cycle.
REQ-034 cdf_valid during RUN with a pixel pending under backpressure:
- Pending pixel is delivered with the old LUT, then cdf_ready rises.
- Reset pulse mid-CALC -> lut_valid = 0 and FSM returns to LOAD.
